pio_irq_servicer: RTL and testbench
===================================

// Module: pio_irq_servicer
// PURPOSE
//  Avalon-MM master that services the edge-capture interrupts of NUM_PIO button PIO slaves
//  (move_left, move_right, rotate, drop).
//  After reset it sets irq_mask=1 in every PIO. It then round-robins over asserted irq lines.
//  For each one it reads edge_capture, clears it by writing, and emits one game-event token
//  to the Tetris control FSM.
//  It sits between the Avalon interconnect and the game logic, replacing CPU interrupt service.
// PARAMETERS
//  NUM_PIO    4     number of PIO slaves serviced (1..8)
//  ADDR_W     8     m_address width, byte address
//  PIO_STRIDE 16    byte distance between consecutive PIO base addresses; PIO i base = i*PIO_STRIDE
//  IDW        3     event_id width; must be >= clog2(NUM_PIO)
// PORTS
//  clk             in   1        system clock
//  reset           in   1        synchronous, active-high reset
//  pio_irq         in   NUM_PIO  irq outputs of PIO 0..NUM_PIO-1, same clock domain
//  m_address       out  ADDR_W   byte address = base + 4*reg_offset
//  m_read          out  1        read request, held until accepted
//  m_write         out  1        write request, held until accepted
//  m_writedata     out  32       write data
//  m_readdata      in   32       read data
//  m_waitrequest   in   1        slave stall; a request is accepted on a cycle with it low
//  m_readdatavalid in   1        m_readdata valid; read latency >= 1 cycle
//  event_valid     out  1        event token present
//  event_id        out  IDW      index of the PIO that produced the event
//  event_ready     in   1        consumer accepts on valid&&ready
//  init_done       out  1        high once all irq_mask writes have completed
// BEHAVIOUR
//  Reset (sync): outputs go to 0 on the next edge: m_read, m_write, m_writedata, m_address,
//   event_valid, event_id, init_done. Round-robin pointer goes to 0. State goes to INIT with idx=0.
//   A reset during any transaction aborts it. Any m_readdatavalid arriving in INIT is ignored.
//  INIT: issue write, address idx*STRIDE+8 (irq_mask), data 32'h1. Hold until !waitrequest.
//   Then idx++. After NUM_PIO-1 is accepted, set init_done=1 (sticky until reset) and go to IDLE.
//  IDLE: if pio_irq!=0, choose the first set bit at or after rr_ptr, wrapping modulo NUM_PIO.
//   Latch it into sel and go to RD. Otherwise stay in IDLE.
//  RD: m_read=1, address sel*STRIDE+12 (edge_capture). Hold until !waitrequest, then go to WAIT_RD.
//  WAIT_RD: wait for readdatavalid.
//   If m_readdata[0]=1, go to CLR.
//   Otherwise (spurious), set rr_ptr=sel+1 and go to IDLE with no write and no event.
//  CLR: m_write=1, address sel*STRIDE+12, data 0. Hold until !waitrequest, then go to EMIT.
//   Clearing happens before emitting, so an edge arriving after the clear is captured again.
//  EMIT: event_valid=1, event_id=sel. Hold until event_ready.
//   On handshake, event_valid=0, rr_ptr=(sel+1) mod NUM_PIO, go to IDLE.
//   While event_ready stays low, no other PIO is serviced; irqs remain pending in the PIOs.
//  Latency: irq high in IDLE at cycle 0, no waitrequest, read latency 1:
//   RD accepted at c1, data at c2, CLR at c3, event_valid at c4.
//  m_read and m_write are never high together. Only one transaction is outstanding at a time.
//  Simultaneous irqs: serviced one per pass in round-robin order; none is lost.
//  An irq line that drops before it is sampled in IDLE is not serviced.
// STRUCTURE
//  Shared header pio_regs.vh holds:
//   - register offsets PIO_DATA=0, PIO_DIR=1, PIO_IRQ_MASK=2, PIO_EDGE_CAP=3
//   - FSM state encodings INIT, IDLE, RD, WAIT_RD, CLR, EMIT
//  One sub-module, rr_pick: combinational round-robin first-set finder.
//   Inputs: req[NUM_PIO], ptr. Outputs: grant index, any.
// TESTING
//  1 Reset, no waitrequest: four writes of data 1 to addresses 0x08, 0x18, 0x28, 0x38, then init_done=1.
//  2 pio_irq=4'b0010 in IDLE, readdata=1: read 0x1C at c1, write 0 to 0x1C at c3,
//    event_valid with id=1 at c4.
//  3 pio_irq=4'b1001 held, event_ready=1: events in id order 0, 3, 0, 3; rr_ptr wraps correctly.
//  4 waitrequest high 3 cycles on RD and on CLR: address, read/write and data stay stable;
//    exactly one transaction of each.
//  5 readdata=0 for irq on PIO 2: no write, no event, return to IDLE; next service starts at PIO 3.
//  6 event_ready low 10 cycles with pio_irq=4'b0100 pending:
//    no bus activity, event_valid and id held stable.
//  7 Reset asserted in WAIT_RD with a late readdatavalid: the data is ignored
//    and the INIT sequence restarts at 0x08.

Source files
------------

// File: rtl/pio_irq_servicer_pkg.sv
// Shared definitions for the PIO interrupt servicer: register offsets
// inside one PIO slave, FSM state encodings and the address helper.
package pio_irq_servicer_pkg;

  // Word offsets of the registers inside one PIO slave
  localparam int PIO_DATA     = 0;
  localparam int PIO_DIR      = 1;
  localparam int PIO_IRQ_MASK = 2;
  localparam int PIO_EDGE_CAP = 3;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD      = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_CLR     = 3'd4,
    ST_EMIT    = 3'd5
  } state_t;

  // Byte address of a register: PIO base (index * stride) plus 4 bytes per word
  function automatic int reg_addr(input int pio_idx, input int stride, input int offset);
    return pio_idx * stride + 4 * offset;
  endfunction

endpackage

// File: rtl/pio_irq_servicer_rr_pick.sv
// Combinational round-robin finder: returns the first set request at or
// after ptr, wrapping modulo NUM_PIO, and whether any request is set.
module pio_irq_servicer_rr_pick #(
  parameter int NUM_PIO = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_PIO-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      grant,
  output logic               any
);

  function automatic logic [PW-1:0] wrap_idx(input int k);
    return PW'(k % NUM_PIO);
  endfunction

  // Scan NUM_PIO positions starting at ptr; the first hit wins
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_PIO; i++) begin
      if (!any && req[wrap_idx(int'(ptr) + i)]) begin
        any   = 1'b1;
        grant = wrap_idx(int'(ptr) + i);
      end
    end
  end

endmodule

// File: rtl/pio_irq_servicer.sv
// Avalon-MM master replacing CPU interrupt service for the button PIOs.
// After reset it enables irq_mask in every PIO, then services asserted
// irq lines round-robin: read edge_capture, clear it, emit one event token.
//
// Handshakes: a bus request (m_read or m_write with address/data) is held
// stable until a cycle with m_waitrequest low, which accepts it; read data
// counts only when m_readdatavalid is high; an event token is held with
// event_valid high until a cycle with event_ready high, which consumes it.
module pio_irq_servicer
  import pio_irq_servicer_pkg::*;
#(
  parameter int NUM_PIO    = 4,
  parameter int ADDR_W     = 8,
  parameter int PIO_STRIDE = 16,
  parameter int IDW        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_PIO-1:0] pio_irq,
  output logic [ADDR_W-1:0]  m_address,
  output logic               m_read,
  output logic               m_write,
  output logic [31:0]        m_writedata,
  input  logic [31:0]        m_readdata,
  input  logic               m_waitrequest,
  input  logic               m_readdatavalid,
  output logic               event_valid,
  output logic [IDW-1:0]     event_id,
  input  logic               event_ready,
  output logic               init_done,
  output logic [2:0]         fsm_state
);

  localparam int PW = (NUM_PIO > 1) ? $clog2(NUM_PIO) : 1;

  state_t        state;
  logic [PW-1:0] idx;
  logic [PW-1:0] sel;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;
  logic          any;

  // Only bit 0 of edge_capture matters: each PIO has a single button input
  logic unused_readdata;
  assign unused_readdata = ^m_readdata[31:1];

  assign fsm_state = state;

  function automatic logic [ADDR_W-1:0] pio_addr(input logic [PW-1:0] i, input int offset);
    return ADDR_W'(reg_addr(int'(i), PIO_STRIDE, offset));
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (int'(v) == NUM_PIO - 1) ? '0 : v + 1'b1;
  endfunction

  pio_irq_servicer_rr_pick #(
    .NUM_PIO (NUM_PIO),
    .PW      (PW)
  ) u_rr_pick (
    .req   (pio_irq),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (any)
  );

  // Servicing FSM; every bus and event output is a register
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      idx         <= '0;
      sel         <= '0;
      rr_ptr      <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= '0;
      m_address   <= '0;
      event_valid <= 1'b0;
      event_id    <= '0;
      init_done   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // First cycle after reset launches the write for idx 0; later
          // writes follow back-to-back as each one is accepted.
          if (!m_write) begin
            m_write     <= 1'b1;
            m_address   <= pio_addr(idx, PIO_IRQ_MASK);
            m_writedata <= 32'h1;
          end else if (!m_waitrequest) begin
            if (int'(idx) == NUM_PIO - 1) begin
              m_write   <= 1'b0;
              init_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              idx       <= idx + 1'b1;
              m_address <= pio_addr(idx + 1'b1, PIO_IRQ_MASK);
            end
          end
        end
        ST_IDLE: begin
          if (any) begin
            sel       <= grant;
            m_read    <= 1'b1;
            m_address <= pio_addr(grant, PIO_EDGE_CAP);
            state     <= ST_RD;
          end
        end
        ST_RD: begin
          if (!m_waitrequest) begin
            m_read <= 1'b0;
            state  <= ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (m_readdatavalid) begin
            if (m_readdata[0]) begin
              m_write     <= 1'b1;
              m_address   <= pio_addr(sel, PIO_EDGE_CAP);
              m_writedata <= '0;
              state       <= ST_CLR;
            end else begin
              // Spurious: nothing captured, move past this PIO silently
              rr_ptr <= wrap_inc(sel);
              state  <= ST_IDLE;
            end
          end
        end
        ST_CLR: begin
          // Clear before emitting so a new edge during EMIT is captured again
          if (!m_waitrequest) begin
            m_write     <= 1'b0;
            event_valid <= 1'b1;
            event_id    <= IDW'(sel);
            state       <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (event_ready) begin
            event_valid <= 1'b0;
            rr_ptr      <= wrap_inc(sel);
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Bench for pio_irq_servicer: an Avalon slave/PIO model with configurable
// stalls and read latency, directed sequences, a vector table and a
// randomized round-robin check against a queue-based reference.
module tb_pio_irq_servicer;
  import pio_irq_servicer_pkg::*;

  localparam int NUM_PIO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NUM_PIO-1:0] pio_irq = '0;
  logic [7:0]         m_address;
  logic               m_read, m_write;
  logic [31:0]        m_writedata;
  logic [31:0]        m_readdata = '0;
  logic               m_waitrequest = 1'b0;
  logic               m_readdatavalid = 1'b0;
  logic               event_valid;
  logic [2:0]         event_id;
  logic               event_ready = 1'b0;
  logic               init_done;
  logic [2:0]         fsm_state;

  pio_irq_servicer #(
    .NUM_PIO(NUM_PIO), .ADDR_W(8), .PIO_STRIDE(16), .IDW(3)
  ) dut (
    .clk(clk), .reset(reset), .pio_irq(pio_irq),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
    .event_valid(event_valid), .event_id(event_id), .event_ready(event_ready),
    .init_done(init_done), .fsm_state(fsm_state)
  );

  // ---------------- bench state ----------------
  int total = 0;
  int bad = 0;

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [31:0] data;
    int         cyc;
  } bus_t;

  bus_t       bus_log[$];
  logic [2:0] ev_log[$];
  int         ev_cyc[$];
  logic [2:0] exp_q[$];
  int         overlap_cnt = 0;
  int         stable_errs = 0;

  bit          model_mode = 0;
  logic [3:0]  cap = '0;
  logic [31:0] cfg_rdata = 32'h1;
  int          cfg_stall = 0;
  bit          stall_rand = 0;
  int          stall_max = 0;
  int          cfg_lat = 1;
  bit          lat_rand = 0;
  bit          cfg_ready = 1;
  bit          ready_rand = 0;

  // slave-private state
  bit   req_seen = 0;
  int   stall_left = 0;
  bit   rd_pending = 0;
  int   rd_cnt = 0;
  logic [31:0] rd_data = '0;
  bit   prev_stalled = 0;
  bus_t prev_req;
  bit   prev_hold = 0;
  logic [2:0] prev_id = '0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int have, input int need);
    total++;
    bad++;
    $display("FAIL %s: timeout, count %0d needed %0d", name, have, need);
  endtask

  task automatic check_bus(input string name, input int i, input bit we,
                           input logic [7:0] addr, input logic [31:0] data);
    if (i >= bus_log.size()) begin
      timeout(name, bus_log.size(), i + 1);
    end else begin
      check({name, "_we"}, 32'(bus_log[i].we), 32'(we));
      check({name, "_addr"}, 32'(bus_log[i].addr), 32'(addr));
      if (we) check({name, "_data"}, bus_log[i].data, data);
    end
  endtask

  task automatic check_ev(input string name, input int i, input logic [2:0] id);
    if (i >= ev_log.size()) timeout(name, ev_log.size(), i + 1);
    else check(name, 32'(ev_log[i]), 32'(id));
  endtask

  task automatic wait_bus(input int n, input int budget, input string name);
    int i = 0;
    while (bus_log.size() < n && i < budget) begin tick(); i++; end
    if (bus_log.size() < n) timeout(name, bus_log.size(), n);
  endtask

  task automatic wait_ev(input int n, input int budget, input string name);
    int i = 0;
    while (ev_log.size() < n && i < budget) begin tick(); i++; end
    if (ev_log.size() < n) timeout(name, ev_log.size(), n);
  endtask

  task automatic wait_init(input int budget, input string name);
    int i = 0;
    while (!init_done && i < budget) begin tick(); i++; end
    if (!init_done) timeout(name, 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pio_irq = '0;
    model_mode = 0; cap = '0; cfg_rdata = 32'h1;
    cfg_stall = 0; stall_rand = 0; stall_max = 0;
    cfg_lat = 1; lat_rand = 0; cfg_ready = 1; ready_rand = 0;
    tick(); tick();
    reset = 1'b0;
    wait_init(200, "reinit");
    tick();
  endtask

  // ---------------- Avalon slave / PIO model / monitors ----------------
  initial begin : slave
    forever begin
      @(negedge clk);
      // read response path keeps running through reset (late data case)
      m_readdatavalid = 1'b0;
      m_readdata = $urandom();
      if (rd_pending) begin
        if (rd_cnt <= 1) begin
          m_readdatavalid = 1'b1;
          m_readdata = rd_data;
          rd_pending = 0;
        end else begin
          rd_cnt--;
        end
      end
      event_ready = ready_rand ? 1'($urandom_range(0, 1)) : cfg_ready;
      if (reset) begin
        req_seen = 0; stall_left = 0; prev_stalled = 0; prev_hold = 0;
        m_waitrequest = 1'b0;
      end else begin
        if (m_read && m_write) overlap_cnt++;
        if (prev_stalled) begin
          if (!((m_read || m_write) && (m_write == prev_req.we) &&
                (m_address == prev_req.addr) &&
                (!m_write || m_writedata == prev_req.data)))
            stable_errs++;
        end
        if (m_read || m_write) begin
          if (!req_seen) begin
            req_seen = 1;
            stall_left = stall_rand ? $urandom_range(0, stall_max) : cfg_stall;
          end
          prev_req = '{we: m_write, addr: m_address, data: m_writedata, cyc: cyc};
          if (stall_left > 0) begin
            m_waitrequest = 1'b1;
            stall_left--;
            prev_stalled = 1;
          end else begin
            m_waitrequest = 1'b0;
            prev_stalled = 0;
            req_seen = 0;
            bus_log.push_back(prev_req);
            if (m_read) begin
              rd_pending = 1;
              rd_cnt = lat_rand ? $urandom_range(1, 3) : cfg_lat;
              rd_data = model_mode ? {31'b0, cap[m_address[5:4]]} : cfg_rdata;
            end else if (model_mode && m_address[3:0] == 4'hC) begin
              cap[m_address[5:4]] = 1'b0;
            end
          end
        end else begin
          m_waitrequest = 1'b0;
          prev_stalled = 0;
        end
        if (prev_hold && !(event_valid && event_id == prev_id)) stable_errs++;
        prev_hold = event_valid && !event_ready;
        prev_id = event_id;
        if (event_valid && event_ready) begin
          ev_log.push_back(event_id);
          ev_cyc.push_back(cyc);
        end
      end
      if (model_mode) pio_irq = cap;
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [3:0]  irq;
    logic [31:0] rdata;
    logic [7:0]  exp_addr;
    bit          exp_evt;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t vecs[8];

  // ---------------- test sequence ----------------
  initial begin : main
    int nb, ne, k0, ptr, last, cnt, st0;
    logic [3:0] mask;

    vecs[0] = '{4'b0010, 32'h1,         8'h1C, 1'b1, 3'd1};
    vecs[1] = '{4'b0011, 32'h1,         8'h0C, 1'b1, 3'd0};
    vecs[2] = '{4'b1100, 32'h1,         8'h2C, 1'b1, 3'd2};
    vecs[3] = '{4'b0001, 32'h0,         8'h0C, 1'b0, 3'd0};
    vecs[4] = '{4'b1111, 32'h1,         8'h1C, 1'b1, 3'd1};
    vecs[5] = '{4'b1000, 32'h3,         8'h3C, 1'b1, 3'd3};
    vecs[6] = '{4'b0110, 32'hFFFF_FFFE, 8'h1C, 1'b0, 3'd0};
    vecs[7] = '{4'b0110, 32'h1,         8'h2C, 1'b1, 3'd2};

    // Test 1: reset values and INIT mask writes
    reset = 1'b1;
    tick(); tick();
    check("rst_init_done", 32'(init_done), 0);
    check("rst_m_read", 32'(m_read), 0);
    check("rst_m_write", 32'(m_write), 0);
    check("rst_m_address", 32'(m_address), 0);
    check("rst_m_writedata", m_writedata, 0);
    check("rst_event_valid", 32'(event_valid), 0);
    check("rst_event_id", 32'(event_id), 0);
    check("rst_state", 32'(fsm_state), 32'(ST_INIT));
    nb = bus_log.size();
    reset = 1'b0;
    tick();
    check("init_done_early", 32'(init_done), 0);
    wait_init(100, "init");
    check("init_write_count", 32'(bus_log.size() - nb), 4);
    for (int i = 0; i < 4; i++)
      check_bus("init_wr", nb + i, 1'b1, 8'(i * 16 + 8), 32'h1);

    // Test 2: single irq latency
    tick(); tick();
    k0 = cyc;
    nb = bus_log.size();
    ne = ev_log.size();
    pio_irq = 4'b0010;
    wait_bus(nb + 1, 20, "lat_read");
    pio_irq = '0;
    wait_ev(ne + 1, 20, "lat_event");
    check_bus("lat_rd", nb, 1'b0, 8'h1C, 32'h0);
    check_bus("lat_clr", nb + 1, 1'b1, 8'h1C, 32'h0);
    if (bus_log.size() >= nb + 2) begin
      check("lat_rd_cycle", 32'(bus_log[nb].cyc - k0), 1);
      check("lat_clr_cycle", 32'(bus_log[nb + 1].cyc - k0), 3);
    end
    if (ev_cyc.size() > ne) check("lat_event_cycle", 32'(ev_cyc[ne] - k0), 4);
    check_ev("lat_event_id", ne, 3'd1);

    // Vector table: single services with hand-derived round-robin order
    do_reset();
    for (int v = 0; v < 8; v++) begin
      nb = bus_log.size();
      ne = ev_log.size();
      cfg_rdata = vecs[v].rdata;
      pio_irq = vecs[v].irq;
      wait_bus(nb + 1, 50, "vec_read");
      pio_irq = '0;
      repeat (12) tick();
      check_bus($sformatf("vec%0d_rd", v), nb, 1'b0, vecs[v].exp_addr, 32'h0);
      if (vecs[v].exp_evt) begin
        check($sformatf("vec%0d_bus_count", v), 32'(bus_log.size() - nb), 2);
        check_bus($sformatf("vec%0d_clr", v), nb + 1, 1'b1, vecs[v].exp_addr, 32'h0);
        check($sformatf("vec%0d_ev_count", v), 32'(ev_log.size() - ne), 1);
        check_ev($sformatf("vec%0d_id", v), ne, vecs[v].exp_id);
      end else begin
        check($sformatf("vec%0d_bus_count", v), 32'(bus_log.size() - nb), 1);
        check($sformatf("vec%0d_ev_count", v), 32'(ev_log.size() - ne), 0);
      end
    end

    // Test 3: two held irqs alternate 0,3,0,3
    do_reset();
    ne = ev_log.size();
    pio_irq = 4'b1001;
    wait_ev(ne + 4, 100, "rr_events");
    pio_irq = '0;
    check_ev("rr_ev0", ne, 3'd0);
    check_ev("rr_ev1", ne + 1, 3'd3);
    check_ev("rr_ev2", ne + 2, 3'd0);
    check_ev("rr_ev3", ne + 3, 3'd3);
    repeat (20) tick();

    // Test 4: 3-cycle stalls on RD and CLR
    do_reset();
    cfg_stall = 3;
    st0 = stable_errs;
    nb = bus_log.size();
    ne = ev_log.size();
    pio_irq = 4'b0100;
    wait_bus(nb + 1, 30, "stall_read");
    pio_irq = '0;
    repeat (30) tick();
    check("stall_bus_count", 32'(bus_log.size() - nb), 2);
    check_bus("stall_rd", nb, 1'b0, 8'h2C, 32'h0);
    check_bus("stall_clr", nb + 1, 1'b1, 8'h2C, 32'h0);
    check("stall_stable", 32'(stable_errs - st0), 0);
    check("stall_ev_count", 32'(ev_log.size() - ne), 1);
    check_ev("stall_id", ne, 3'd2);

    // Test 5: spurious read on PIO 2, next service starts at PIO 3
    do_reset();
    cfg_rdata = 32'h0;
    nb = bus_log.size();
    ne = ev_log.size();
    pio_irq = 4'b0100;
    wait_bus(nb + 1, 30, "spur_read");
    pio_irq = '0;
    repeat (10) tick();
    check("spur_bus_count", 32'(bus_log.size() - nb), 1);
    check_bus("spur_rd", nb, 1'b0, 8'h2C, 32'h0);
    check("spur_ev_count", 32'(ev_log.size() - ne), 0);
    cfg_rdata = 32'h1;
    nb = bus_log.size();
    pio_irq = 4'b1111;
    wait_bus(nb + 1, 30, "spur_next");
    pio_irq = '0;
    check_bus("spur_next_rd", nb, 1'b0, 8'h3C, 32'h0);
    repeat (12) tick();

    // Test 6: consumer stalls for 10 cycles
    do_reset();
    cfg_ready = 0;
    ne = ev_log.size();
    pio_irq = 4'b0100;
    cnt = 0;
    while (!event_valid && cnt < 30) begin tick(); cnt++; end
    if (!event_valid) timeout("hold_valid_wait", 0, 1);
    pio_irq = '0;
    nb = bus_log.size();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(event_valid), 1);
      check("hold_id", 32'(event_id), 2);
      check("hold_no_bus", 32'(m_read | m_write), 0);
    end
    check("hold_bus_count", 32'(bus_log.size() - nb), 0);
    cfg_ready = 1;
    wait_ev(ne + 1, 10, "hold_release");
    check_ev("hold_ev_id", ne, 3'd2);
    repeat (5) tick();

    // Test 7: reset in WAIT_RD, late read data arrives during INIT
    do_reset();
    cfg_lat = 4;
    ne = ev_log.size();
    nb = bus_log.size();
    pio_irq = 4'b0001;
    wait_bus(nb + 1, 30, "late_read");
    pio_irq = '0;
    tick();
    reset = 1'b1;
    cfg_stall = 3;
    tick();
    reset = 1'b0;
    nb = bus_log.size();
    wait_init(100, "late_init");
    repeat (10) tick();
    check("late_bus_count", 32'(bus_log.size() - nb), 4);
    for (int i = 0; i < 4; i++)
      check_bus("late_init_wr", nb + i, 1'b1, 8'(i * 16 + 8), 32'h1);
    check("late_ev_count", 32'(ev_log.size() - ne), 0);

    // Randomized batches against a round-robin reference
    do_reset();
    model_mode = 1; stall_rand = 1; stall_max = 2; lat_rand = 1; ready_rand = 1;
    ptr = 0;
    for (int b = 0; b < 30; b++) begin
      mask = 4'($urandom_range(1, 15));
      nb = bus_log.size();
      ne = ev_log.size();
      exp_q.delete();
      last = ptr;
      for (int j = 0; j < NUM_PIO; j++) begin
        if (mask[(ptr + j) % NUM_PIO]) begin
          exp_q.push_back(3'((ptr + j) % NUM_PIO));
          last = (ptr + j) % NUM_PIO;
        end
      end
      ptr = (last + 1) % NUM_PIO;
      cnt = exp_q.size();
      cap = mask;
      wait_ev(ne + cnt, 400, "rand_events");
      repeat (3) tick();
      check($sformatf("rand%0d_bus_count", b), 32'(bus_log.size() - nb), 32'(2 * cnt));
      for (int i = 0; i < cnt; i++) begin
        check_ev($sformatf("rand%0d_ev%0d", b, i), ne + i, exp_q[i]);
        check_bus("rand_rd", nb + 2 * i, 1'b0, 8'(int'(exp_q[i]) * 16 + 12), 32'h0);
        check_bus("rand_clr", nb + 2 * i + 1, 1'b1, 8'(int'(exp_q[i]) * 16 + 12), 32'h0);
      end
    end

    check("no_read_write_overlap", 32'(overlap_cnt), 0);
    check("request_event_stability", 32'(stable_errs), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
